match_game_core: RTL and testbench

Parametrised successor to the single-round switch-matching game controller. It draws a non-zero random target, accepts player submissions on `sw`, and scores hits with a saturating counter. It runs either a timed game or a fixed number of rounds, with a per-round timeout, a lives budget and a best-score register. It sits between the debounced button shapers and the 7-segment decoders; all outputs are binary, and display decoding stays outside.

---
 rtl/match_game_pkg.sv | 13 +
 rtl/match_game_core_if.sv | 20 ++
 rtl/match_game_core_lfsr_gen.sv | 19 +
 rtl/match_game_core.sv | 102 ++++++++++
 tb/tb_match_game_core.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/match_game_pkg.sv
// match_game_pkg: shared FSM state type, game mode encodings and LFSR tap table.
package match_game_pkg;
  typedef enum logic [1:0] {IDLE, DRAW, PLAY, FINISH} state_t;
  localparam logic MODE_TIMED = 1'b0;
  localparam logic MODE_ROUNDS = 1'b1;
  // Maximal-length Fibonacci tap masks, bit n-1 set for polynomial term x^n
  function automatic logic [15:0] lfsr_taps(input int w);
    return w == 4 ? 16'h000C : w == 5 ? 16'h0014 : w == 6 ? 16'h0030 :
           w == 7 ? 16'h0060 : w == 8 ? 16'h00B8 : w == 9 ? 16'h0110 :
           w == 10 ? 16'h0240 : w == 11 ? 16'h0500 : w == 12 ? 16'h0829 :
           w == 13 ? 16'h100D : w == 14 ? 16'h2015 : w == 15 ? 16'h6000 : 16'hD008;
  endfunction
endpackage

// File: rtl/match_game_core_if.sv
// match_game_core_if: player-side controls and game status outputs of the match game.
interface match_game_core_if #(parameter int SW_W = 4, parameter int SCORE_W = 8, parameter int TL_W = 8);
  logic start;
  logic submit;
  logic mode;
  logic [SW_W-1:0] sw;
  logic [SW_W-1:0] target;
  logic target_valid;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] best;
  logic [TL_W-1:0] time_left;
  logic hit;
  logic miss;
  logic busy;
  logic done;
  modport master (output start, submit, mode, sw,
                  input target, target_valid, score, best, time_left, hit, miss, busy, done);
  modport slave (input start, submit, mode, sw,
                 output target, target_valid, score, best, time_left, hit, miss, busy, done);
endinterface

// File: rtl/match_game_core_lfsr_gen.sv
// lfsr_gen: free-running maximal-length Fibonacci LFSR (WIDTH 4..16); a non-zero seed keeps it off zero.
module lfsr_gen
  import match_game_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OUT_W = 4,
  parameter logic [WIDTH-1:0] SEED = WIDTH'(1)
) (
  input  logic clk,
  input  logic reset,
  output logic [OUT_W-1:0] rnd
);
  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));
  logic [WIDTH-1:0] q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= SEED;
    else q <= {q[WIDTH-2:0], ^(q & TAPS)};
  assign rnd = q[OUT_W-1:0];
endmodule

// File: rtl/match_game_core.sv
// match_game_core: switch-matching game with timed/lives and fixed-rounds modes, saturating score and best-score register.
module match_game_core
  import match_game_pkg::*;
#(
  parameter int SW_W = 4,
  parameter int SCORE_W = 8,
  parameter int ROUNDS = 10,
  parameter int ROUND_CYCLES = 200,
  parameter int GAME_CYCLES = 2000,
  parameter int LIVES = 3
) (
  input logic clk,
  input logic reset,
  match_game_core_if.slave bus
);
  localparam int TL_W = $clog2(ROUND_CYCLES + 1);
  localparam int RW = $clog2(ROUNDS + 1);
  localparam int MW = $clog2(LIVES + 1);
  localparam int GW = $clog2(GAME_CYCLES + 1);
  localparam int LW = SW_W > 8 ? SW_W : 8;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [TL_W-1:0] TL_INIT = TL_W'(ROUND_CYCLES);
  localparam logic [RW-1:0] ROUNDS_L = RW'(ROUNDS);
  localparam logic [MW-1:0] LIVES_L = MW'(LIVES);
  localparam logic [GW-1:0] GAME_LAST = GW'(GAME_CYCLES - 1);

  state_t state, state_n;
  logic mode_q;
  logic [SW_W-1:0] target, rnd;
  logic [SCORE_W-1:0] score, score_n, best;
  logic [TL_W-1:0] time_left, time_left_n;
  logic [RW-1:0] rounds, rounds_n;
  logic [MW-1:0] misses, misses_n;
  logic [GW-1:0] timer;
  logic hit, miss, ev_hit, ev_miss, scored, expire, over, clear, active;

  lfsr_gen #(.WIDTH(LW), .OUT_W(SW_W)) u_lfsr (.clk(clk), .reset(reset), .rnd(rnd));

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;

  // A submit always wins over the round timeout, so one PLAY cycle scores at most one event
  always_comb begin
    active = state == DRAW || state == PLAY;
    clear = bus.start && (state == IDLE || state == FINISH);
    scored = state == PLAY && (bus.submit || time_left == TL_W'(1));
    ev_hit = state == PLAY && bus.submit && bus.sw == target;
    ev_miss = scored && !ev_hit;
    score_n = ev_hit && score != SCORE_MAX ? score + SCORE_W'(1) : score;
    rounds_n = rounds + RW'(scored);
    misses_n = misses + MW'(ev_miss);
    expire = active && timer == GAME_LAST;
    over = mode_q == MODE_ROUNDS ? rounds_n == ROUNDS_L : expire || misses_n == LIVES_L;
    state_n = clear ? DRAW :
              state == DRAW ? (over ? FINISH : rnd != '0 ? PLAY : DRAW) :
              state == PLAY ? (over ? FINISH : scored ? DRAW : PLAY) : state;
    time_left_n = state_n == PLAY ? (state == PLAY ? time_left - TL_W'(1) : TL_INIT) : '0;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mode_q <= MODE_TIMED;
      target <= '0;
      score <= '0;
      best <= '0;
      time_left <= '0;
      rounds <= '0;
      misses <= '0;
      timer <= '0;
      hit <= 1'b0;
      miss <= 1'b0;
    end else begin
      hit <= ev_hit;
      miss <= ev_miss;
      time_left <= time_left_n;
      if (state == DRAW && rnd != '0) target <= rnd;
      if (state_n == FINISH && state != FINISH && score_n > best) best <= score_n;
      if (clear) begin
        mode_q <= bus.mode;
        score <= '0;
        rounds <= '0;
        misses <= '0;
        timer <= '0;
      end else begin
        score <= score_n;
        rounds <= rounds_n;
        misses <= misses_n;
        if (active) timer <= timer + GW'(1);
      end
    end

  assign bus.target = target;
  assign bus.target_valid = state == PLAY;
  assign bus.score = score;
  assign bus.best = best;
  assign bus.time_left = time_left;
  assign bus.hit = hit;
  assign bus.miss = miss;
  assign bus.busy = active;
  assign bus.done = state == FINISH;
endmodule

// File: tb/tb_match_game_core.sv
// tb_match_game_core: scoreboard bench for two match_game_core configurations (8-bit score, 2-bit saturating score).
module tb_match_game_core;
  import match_game_pkg::*;
  localparam int RC = 20;
  localparam int GA = 300;
  localparam int TLW = $clog2(RC + 1);

  typedef struct packed {logic hit; logic miss; logic [7:0] score; logic done;} ev_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int cyc = 0;
  int t0 = 0;
  int tests = 0;
  int fails = 0;
  ev_t qa[$];
  ev_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  match_game_core_if #(.SW_W(4), .SCORE_W(8), .TL_W(TLW)) a();
  match_game_core_if #(.SW_W(4), .SCORE_W(2), .TL_W(TLW)) b();

  match_game_core #(.SW_W(4), .SCORE_W(8), .ROUNDS(3), .ROUND_CYCLES(RC), .GAME_CYCLES(GA), .LIVES(3))
    dut_a (.clk(clk), .reset(reset), .bus(a));
  match_game_core #(.SW_W(4), .SCORE_W(2), .ROUNDS(5), .ROUND_CYCLES(RC), .GAME_CYCLES(2000), .LIVES(3))
    dut_b (.clk(clk), .reset(reset), .bus(b));

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic ev_t mk(bit h, bit m, int sc, bit d);
    return {h, m, 8'(sc), d};
  endfunction

  function automatic logic tv(bit s);
    return s ? b.target_valid : a.target_valid;
  endfunction

  function automatic logic [3:0] tgt(bit s);
    return s ? b.target : a.target;
  endfunction

  function automatic logic [31:0] tl(bit s);
    return s ? 32'(b.time_left) : 32'(a.time_left);
  endfunction

  ev_t ea, eb;
  always @(negedge clk)
    if (reset && (a.hit || a.miss)) begin
      if (qa.size() == 0) check("a_unexpected_event", {a.hit, a.miss, a.score, a.done}, 0);
      else begin
        ea = qa.pop_front();
        check("a_event", {a.hit, a.miss, a.score, a.done}, ea);
      end
    end

  always @(negedge clk)
    if (reset && (b.hit || b.miss)) begin
      if (qb.size() == 0) check("b_unexpected_event", {b.hit, b.miss, 6'b0, b.score, b.done}, 0);
      else begin
        eb = qb.pop_front();
        check("b_event", {b.hit, b.miss, 6'b0, b.score, b.done}, eb);
      end
    end

  task automatic start_game(bit s, logic md);
    @(posedge clk); #1;
    if (s) begin b.start = 1'b1; b.mode = md; end
    else begin a.start = 1'b1; a.mode = md; end
    @(posedge clk); #1;
    a.start = 1'b0;
    b.start = 1'b0;
    t0 = cyc;
    check("busy_after_start", s ? b.busy : a.busy, 1);
  endtask

  task automatic wait_play(bit s);
    int n;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!tv(s) && n < 50);
    check("wait_play", tv(s), 1);
    check("time_left_load", tl(s), RC);
    check("target_nonzero", tgt(s) != 4'd0, 1);
  endtask

  task automatic submit(bit s, bit good, ev_t e);
    logic [3:0] t;
    t = tgt(s);
    if (s) begin qb.push_back(e); b.sw = good ? t : ~t; b.submit = 1'b1; end
    else begin qa.push_back(e); a.sw = good ? t : ~t; a.submit = 1'b1; end
    @(posedge clk); #1;
    a.submit = 1'b0;
    b.submit = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sa, sb;
    bit fin;
    a.start = 0; a.submit = 0; a.mode = 0; a.sw = 0;
    b.start = 0; b.submit = 0; b.mode = 0; b.sw = 0;
    repeat (3) @(posedge clk);
    #2;
    check("a_reset_outputs", {a.target, a.target_valid, a.score, a.best, a.time_left, a.hit, a.miss, a.busy, a.done}, 0);
    check("b_reset_outputs", {b.target, b.target_valid, b.score, b.best, b.time_left, b.hit, b.miss, b.busy, b.done}, 0);
    #3 reset = 1'b1;

    // fixed rounds, three hits
    start_game(0, MODE_ROUNDS);
    for (int i = 0; i < 3; i++) begin
      wait_play(0);
      submit(0, 1, mk(1, 0, i + 1, i == 2));
    end
    check("g1_done", a.done, 1);
    check("g1_score", a.score, 3);
    check("g1_best", a.best, 3);
    check("g1_idle_outputs", {a.busy, a.target_valid, a.time_left}, 0);

    // timed game straight from FINISH, three wrong guesses use up the lives
    start_game(0, MODE_TIMED);
    check("g2_score_cleared", a.score, 0);
    for (int i = 0; i < 3; i++) begin
      wait_play(0);
      submit(0, 0, mk(0, 1, 0, i == 2));
    end
    check("g2_done", a.done, 1);
    check("g2_score", a.score, 0);
    check("g2_best_kept", a.best, 3);

    // timeout miss, then a submit on the last cycle of a round, then a final-round hit
    start_game(0, MODE_ROUNDS);
    wait_play(0);
    qa.push_back(mk(0, 1, 0, 0));
    repeat (RC - 1) @(posedge clk);
    #1 check("g3_tl_one", tl(0), 1);
    @(posedge clk); #1;
    check("g3_left_play", {a.target_valid, a.time_left}, 0);
    wait_play(0);
    repeat (RC - 1) @(posedge clk);
    #1 check("g3_tl_one_b", tl(0), 1);
    submit(0, 1, mk(1, 0, 1, 0));
    wait_play(0);
    submit(0, 1, mk(1, 0, 2, 1));
    check("g3_done", a.done, 1);
    check("g3_best", a.best, 3);

    // timed game ended by the game timer, hitting every round as fast as possible
    start_game(0, MODE_TIMED);
    sa = 0;
    fin = 0;
    for (int r = 0; r < 400 && !fin; r++) begin
      do begin @(posedge clk); #1; end while (!a.target_valid && !a.done && cyc - t0 < GA + 5);
      if (a.target_valid) begin
        sa++;
        submit(0, 1, mk(1, 0, sa, (cyc + 1 - t0) == GA));
      end
      fin = a.done || cyc - t0 >= GA + 5;
    end
    check("g4_timer_end_cycle", cyc - t0, GA);
    check("g4_done", a.done, 1);
    check("g4_score", a.score, sa);
    check("g4_best_max", a.best, sa > 3 ? sa : 3);

    // 2-bit score saturates over five hits
    start_game(1, MODE_ROUNDS);
    sb = 0;
    for (int i = 0; i < 5; i++) begin
      wait_play(1);
      sb = sb < 3 ? sb + 1 : 3;
      submit(1, 1, mk(1, 0, sb, i == 4));
    end
    check("b_done", b.done, 1);
    check("b_score_sat", b.score, 3);
    check("b_best", b.best, 3);

    // asynchronous reset in the middle of a round
    start_game(0, MODE_ROUNDS);
    wait_play(0);
    #2 reset = 1'b0;
    #1;
    check("a_midreset_outputs", {a.target, a.target_valid, a.score, a.best, a.time_left, a.hit, a.miss, a.busy, a.done}, 0);
    check("b_midreset_outputs", {b.target, b.target_valid, b.score, b.best, b.time_left, b.hit, b.miss, b.busy, b.done}, 0);
    #10 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("a_idle_after_reset", {a.busy, a.done}, 0);
    check("a_events_drained", qa.size(), 0);
    check("b_events_drained", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
